// File: rtl/rom_text_sequencer_pkg.sv
// Shared types and LCD constants for the ROM-to-LCD text sequencer.
package text_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE
  } state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic       LCD_RS_CMD    = 1'b0;
  localparam logic       LCD_RS_DATA   = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rom_text_sequencer_if.sv
// Bundles the ROM address/data bus, LCD pins and start/busy/done control.
interface rom_text_sequencer_if #(
  parameter int ADDR_W = 4
) ();

  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              lcd_rs;
  logic              lcd_e;
  logic [7:0]        lcd_db;
  logic              busy;
  logic              done;

  modport master (
    input  start, rom_data,
    output rom_addr, lcd_rs, lcd_e, lcd_db, busy, done
  );

  modport slave (
    output start, rom_data,
    input  rom_addr, lcd_rs, lcd_e, lcd_db, busy, done
  );

endinterface

// File: rtl/rom_text_sequencer_lcd_byte_writer.sv
// One LCD byte transfer: SETUP (latch bus), PULSE (lcd_e high), GAP (settle), ack on GAP exit.
module lcd_byte_writer
  import text_seq_pkg::*;
#(
  parameter int EN_HIGH_CYC = 16,
  parameter int SETTLE_CYC  = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req,
  input  logic       i_rs_in,
  input  logic [7:0] i_db_in,
  output logic       o_lcd_e,
  output logic       o_lcd_rs,
  output logic [7:0] o_lcd_db,
  output logic       o_ack
);

  localparam int CNT_W = $clog2(max2(EN_HIGH_CYC, SETTLE_CYC)) + 1;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [7:0]         r_db;
  logic               r_rs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_db    <= '0;
      r_rs    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // rom_data is only valid once rom_addr has settled, i.e. during SETUP
      if (r_state == SETUP) begin
        r_db <= i_db_in;
        r_rs <= i_rs_in;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
    o_ack        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          w_state_next = SETUP;
          w_cnt_next   = '0;
        end
      end
      SETUP: begin
        w_state_next = PULSE;
        w_cnt_next   = CNT_W'(EN_HIGH_CYC - 1);
      end
      PULSE: begin
        if (r_cnt == '0) begin
          w_state_next = GAP;
          w_cnt_next   = CNT_W'(SETTLE_CYC - 1);
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          o_ack        = 1'b1;
          w_state_next = i_req ? SETUP : IDLE;
          w_cnt_next   = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_lcd_e  = (r_state == PULSE);
  assign o_lcd_rs = r_rs;
  assign o_lcd_db = r_db;

endmodule

// File: rtl/rom_text_sequencer.sv
// Clears the LCD then writes MSG_LEN ROM characters; TEXT_SEQ_LOOP_EN makes it repeat forever.
module rom_text_sequencer
  import text_seq_pkg::*;
#(
  parameter int MSG_LEN     = 12,
  parameter int ADDR_W      = 4,
  parameter int EN_HIGH_CYC = 16,
  parameter int SETTLE_CYC  = 2000
) (
  input logic                 clk,
  input logic                 rst_n,
  rom_text_sequencer_if.master bus
);

  localparam int IDX_W = $clog2(MSG_LEN + 1);

  // SETUP here stands for the whole byte loop; the fine phase lives in the writer
  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic [ADDR_W-1:0]  r_rom_addr, w_rom_addr_next;
  logic               w_req;
  logic               w_ack;
  logic               w_last;
  logic               w_rs_in;
  logic [7:0]         w_db_in;

  assign w_last = (r_idx == IDX_W'(MSG_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_rom_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_rom_addr <= w_rom_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_rom_addr_next = r_rom_addr;
    w_req           = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_state_next    = SETUP;
          w_idx_next      = '0;
          w_rom_addr_next = '0;
          w_req           = 1'b1;
        end
      end
      SETUP: begin
        if (w_ack) begin
          if (w_last) begin
`ifdef TEXT_SEQ_LOOP_EN
            w_idx_next      = '0;
            w_rom_addr_next = '0;
            w_req           = 1'b1;
`else
            w_state_next    = DONE;
`endif
          end else begin
            // index k+1 writes character k, so the address trails the index by one
            w_idx_next      = r_idx + IDX_W'(1);
            w_rom_addr_next = ADDR_W'(r_idx);
            w_req           = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_rs_in = (r_idx == '0) ? LCD_RS_CMD    : LCD_RS_DATA;
  assign w_db_in = (r_idx == '0) ? LCD_CMD_CLEAR : bus.rom_data;

  lcd_byte_writer #(
    .EN_HIGH_CYC (EN_HIGH_CYC),
    .SETTLE_CYC  (SETTLE_CYC)
  ) u_writer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_req),
    .i_rs_in  (w_rs_in),
    .i_db_in  (w_db_in),
    .o_lcd_e  (bus.lcd_e),
    .o_lcd_rs (bus.lcd_rs),
    .o_lcd_db (bus.lcd_db),
    .o_ack    (w_ack)
  );

  assign bus.rom_addr = r_rom_addr;
  assign bus.busy     = (r_state == SETUP);
  assign bus.done     = (r_state == DONE);

endmodule

// File: tb/tb_rom_text_sequencer.sv
// Scoreboard bench: stimulus pushes expected LCD bytes/times, a negedge monitor pops and compares.
module tb_rom_text_sequencer;

  localparam int MSG_LEN  = 12;
  localparam int EN       = 4;
  localparam int SET      = 8;
  localparam int BYTE_CYC = 1 + EN + SET;
  localparam int RUN_CYC  = (MSG_LEN + 1) * BYTE_CYC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_text_sequencer_if #(.ADDR_W(4)) bus ();

  rom_text_sequencer #(
    .MSG_LEN     (MSG_LEN),
    .ADDR_W      (4),
    .EN_HIGH_CYC (EN),
    .SETTLE_CYC  (SET)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] rom [16];
  assign bus.rom_data = rom[bus.rom_addr];

  typedef struct {
    logic       rs;
    logic [7:0] db;
    logic [3:0] addr;
    int         t;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected byte stream: clear command, then ROM[0..MSG_LEN-1]; pulse k rises at c0+2+k*BYTE_CYC
  function automatic void push_run(input int c0, input int loops, input bit with_done);
    for (int l = 0; l < loops; l++) begin
      for (int k = 0; k <= MSG_LEN; k++) begin
        exp_t e;
        e.rs   = (k != 0);
        e.db   = (k == 0) ? 8'h01 : rom[k-1];
        e.addr = (k == 0) ? 4'd0 : 4'(k - 1);
        e.t    = c0 + 2 + BYTE_CYC * (l * (MSG_LEN + 1) + k);
        exp_q.push_back(e);
      end
    end
    if (with_done) done_q.push_back(c0 + 1 + RUN_CYC);
  endfunction

  // Monitor
  logic       prev_e, prev_done, held_rs;
  logic [7:0] held_db;
  int         e_len;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_e    = 1'b0;
      prev_done = 1'b0;
      held_rs   = 1'b0;
      held_db   = 8'h00;
      e_len     = 0;
    end else begin
      chk("addr_range", 32'(bus.rom_addr < 4'(MSG_LEN)), 32'd1);
      chk("done_busy_excl", 32'(bus.done & bus.busy), 32'd0);
      if (bus.lcd_e && !prev_e) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got lcd_db %0h required no pulse (cycle %0d)", bus.lcd_db, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_time", 32'(cyc), 32'(e.t));
          chk("pulse_rs", 32'(bus.lcd_rs), 32'(e.rs));
          chk("pulse_db", 32'(bus.lcd_db), 32'(e.db));
          chk("pulse_addr", 32'(bus.rom_addr), 32'(e.addr));
        end
        held_db = bus.lcd_db;
        held_rs = bus.lcd_rs;
        e_len   = 1;
      end else begin
        chk("db_stable", 32'(bus.lcd_db), 32'(held_db));
        chk("rs_stable", 32'(bus.lcd_rs), 32'(held_rs));
        if (bus.lcd_e) e_len++;
        else if (prev_e) chk("pulse_width", 32'(e_len), 32'(EN));
      end
      if (bus.done && !prev_done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
        end else begin
          chk("done_time", 32'(cyc), 32'(done_q.pop_front()));
        end
        chk("done_lcd_e", 32'(bus.lcd_e), 32'd0);
      end
      prev_e    = bus.lcd_e;
      prev_done = bus.done;
    end
  end

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < RUN_CYC + 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    chk("done_reached", 32'(seen), 32'd1);
  endtask

  task automatic randomize_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    string msg;
    int    c0;
    msg = "ENGINEERING ";
    for (int i = 0; i < 16; i++) rom[i] = (i < MSG_LEN) ? msg[i] : 8'hFF;
    bus.start = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_lcd_e", 32'(bus.lcd_e), 32'd0);
    chk("rst_lcd_db", 32'(bus.lcd_db), 32'd0);
    chk("rst_lcd_rs", 32'(bus.lcd_rs), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

`ifdef TEXT_SEQ_LOOP_EN
    bus.start = 1'b1;
    c0 = cyc;
    push_run(c0, 4, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("loop_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 3 * RUN_CYC + 5; i++) begin
      @(negedge clk);
      chk("loop_done_low", 32'(bus.done), 32'd0);
    end
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("loop_rst_e", 32'(bus.lcd_e), 32'd0);
    chk("loop_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    // Run 1: single start pulse with the reference message
    bus.start = 1'b1;
    push_run(cyc, 1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    wait_done();
    repeat (4) @(negedge clk);
    chk("done_hold", 32'(bus.done), 32'd1);
    chk("done_db_hold", 32'(bus.lcd_db), 32'(rom[MSG_LEN-1]));
    chk("done_rs_hold", 32'(bus.lcd_rs), 32'd1);

    // Run 2: start held high through the run, restarted from DONE
    randomize_rom();
    bus.start = 1'b1;
    push_run(cyc, 1, 1'b1);
    repeat ($urandom_range(2, 160)) @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Runs 3..6: random ROM, random idle gaps, random start glitches while busy
    for (int r = 0; r < 4; r++) begin
      randomize_rom();
      repeat ($urandom_range(1, 20)) @(negedge clk);
      bus.start = 1'b1;
      c0 = cyc;
      push_run(c0, 1, 1'b1);
      @(negedge clk);
      while (cyc < c0 + RUN_CYC - 5) begin
        bus.start = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      bus.start = 1'b0;
      wait_done();
    end

    // Asynchronous reset in the middle of the 5th enable pulse
    randomize_rom();
    rom[3] = 8'hA5;
    @(negedge clk);
    bus.start = 1'b1;
    c0 = cyc;
    push_run(c0, 1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < c0 + 3 + 4 * BYTE_CYC) @(negedge clk);
    chk("pre_rst_e", 32'(bus.lcd_e), 32'd1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    chk("arst_lcd_e", 32'(bus.lcd_e), 32'd0);
    chk("arst_lcd_db", 32'(bus.lcd_db), 32'd0);
    chk("arst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_idle_done", 32'(bus.done), 32'd0);

    // Recovery run after reset
    bus.start = 1'b1;
    push_run(cyc, 1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
`endif

    repeat (5) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rom_text_sequencer.md
Name: rom_text_sequencer

Overview:
- Drives the character ROM address bus and writes each returned ASCII byte to an HD44780-style 8-bit parallel character LCD.
- Sits between the message ROM (combinational, 4-bit address, 8-bit data) and the LCD pins.
- On start, it issues a clear-display command, then writes MSG_LEN characters from ROM addresses 0..MSG_LEN-1, with programmable enable-pulse and settle timing.

Parameters:
- MSG_LEN, 12, number of characters read from ROM (1..16).
- ADDR_W, 4, ROM address width.
- EN_HIGH_CYC, 16, clk cycles lcd_e is held high per byte (>=1).
- SETTLE_CYC, 2000, clk cycles lcd_e is held low after each byte before the next byte (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a message write; sampled only in IDLE or DONE.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  8  ROM data, valid combinationally for the current rom_addr.
- lcd_rs  out  1  register select: 0 = command, 1 = data.
- lcd_e  out  1  LCD enable strobe.
- lcd_db  out  8  LCD data bus, registered.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  level; high while in DONE.

Behaviour:
- Reset is asynchronous, active-low, on rst_n. On reset, all outputs go to 0 immediately and the state goes to IDLE. This applies mid-operation too; no partial byte completes.
- States: IDLE, SETUP, PULSE, GAP, DONE.
- IDLE, start=1:
  - Next state is SETUP, busy=1.
  - Byte index is 0 (command slot), rom_addr=0.
- SETUP (1 cycle):
  - Index 0: lcd_db=8'h01, lcd_rs=0.
  - Otherwise: lcd_db=rom_data, lcd_rs=1.
  - lcd_e=0. Next state is PULSE.
- PULSE (EN_HIGH_CYC cycles): lcd_e=1. lcd_db and lcd_rs stay stable. Next state is GAP.
- GAP (SETTLE_CYC cycles): lcd_e=0.
  - On exit: if index==MSG_LEN, go to DONE.
  - Otherwise: index+1, rom_addr=index (the character just about to be written), then SETUP.
- rom_addr sequencing:
  - rom_addr holds 0 for the command slot and for the first character.
  - For character k (index k+1), rom_addr=k is stable for at least the whole SETUP cycle.
- Per-byte cost is 1+EN_HIGH_CYC+SETTLE_CYC cycles. The full run takes (MSG_LEN+1)*(1+EN_HIGH_CYC+SETTLE_CYC) cycles from the first SETUP to DONE entry.
- DONE: busy=0, done=1, lcd_e=0, lcd_db/lcd_rs hold their last values.
  - start=1 restarts at SETUP with index 0; done drops in the same cycle busy rises.
- start while busy is ignored, with no effect on timing.
- Timing counter width is clog2(max(EN_HIGH_CYC, SETTLE_CYC))+1. It reloads on every state entry and counts down to 0.
- Index width is clog2(MSG_LEN+1).
- rom_addr never exceeds MSG_LEN-1.

Optional Feature:
- Macro: TEXT_SEQ_LOOP_EN.
- Defined: on leaving GAP after the last character, the block goes directly to SETUP with index 0 instead of DONE. It re-clears and rewrites continuously; busy stays 1, done never asserts. Only rst_n stops it.
- Undefined: single-shot behaviour as above.

Decomposition:
- Package text_seq_pkg:
  - state enum (IDLE, SETUP, PULSE, GAP, DONE).
  - LCD_CMD_CLEAR=8'h01.
  - LCD_RS_CMD=1'b0, LCD_RS_DATA=1'b1.
- Sub-module lcd_byte_writer:
  - Inputs: req, rs_in, db_in.
  - Handles the SETUP/PULSE/GAP timing and returns a 1-cycle ack at GAP exit.
  - rom_text_sequencer keeps the index, the address and the IDLE/DONE control.

Test Plan (EN_HIGH_CYC=4, SETTLE_CYC=8, MSG_LEN=12, ROM holds "ENGINEERING "):
- Reset then start pulse -> first byte lcd_rs=0, lcd_db=8'h01; lcd_e high for exactly 4 cycles starting 1 cycle after SETUP.
- Full run -> 13 enable pulses; data bytes in order 45 4E 47 49 4E 45 45 52 49 4E 47 20 with lcd_rs=1; done rises 169 cycles after the first SETUP.
- Every pulse -> lcd_db/lcd_rs stable from SETUP through the end of GAP; rom_addr walks 0..11 and never reaches 12.
- start held high throughout the run -> identical waveform to a single pulse; start in DONE -> restart with the clear command.
- rst_n low during the 5th lcd_e pulse -> lcd_e, lcd_db, rom_addr, busy all 0 asynchronously; after release, IDLE until start.
- TEXT_SEQ_LOOP_EN defined -> after character 12, next byte is 8'h01 with lcd_rs=0; done stays 0 for 3 full loops.
